// File: rtl/router_input_port_if.sv
// Link-side and crossbar-side handshake bundle for one router input port.
// The master modport is the upstream/arbiter side; the slave modport is the port itself.
interface router_input_port_if #(
  parameter int unsigned PACKET_WIDTH = 64
);
  logic                    si;
  logic                    ri;
  logic [PACKET_WIDTH-1:0] di;
  logic                    out_valid;
  logic [2:0]              out_dir;
  logic [PACKET_WIDTH-1:0] out_data;
  logic                    out_grant;

  modport master (
    output si, di, out_grant,
    input  ri, out_valid, out_dir, out_data
  );

  modport slave (
    input  si, di, out_grant,
    output ri, out_valid, out_dir, out_data
  );
endinterface

// File: rtl/router_input_port.sv
// Two-VC router input stage: XY route decode with hop decrement on write,
// polarity selects which VC faces the link and which faces the crossbar.
module router_input_port #(
  parameter int unsigned PACKET_WIDTH = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                polarity_i,
  router_input_port_if.slave  port_if,
  output logic [15:0]         pkt_count_o
);

  localparam logic [2:0] DirE  = 3'd0;
  localparam logic [2:0] DirW  = 3'd1;
  localparam logic [2:0] DirN  = 3'd2;
  localparam logic [2:0] DirS  = 3'd3;
  localparam logic [2:0] DirPe = 3'd4;

  logic [PACKET_WIDTH-1:0] pkt_buf_q [2];
  logic [PACKET_WIDTH-1:0] pkt_buf_d [2];
  logic [2:0]              dir_q [2];
  logic [2:0]              dir_d [2];
  logic [1:0]              full_q, full_d;
  logic [15:0]             pkt_count_q, pkt_count_d;

  logic                    lnk_vc, xb_vc;
  logic                    wr_en, rd_en;
  logic [7:0]              hx, hy;
  logic [PACKET_WIDTH-1:0] routed_pkt;
  logic [2:0]              routed_dir;

  assign lnk_vc = polarity_i;
  assign xb_vc  = ~polarity_i;
  assign hx     = port_if.di[55:48];
  assign hy     = port_if.di[47:40];

  assign wr_en = port_if.si & ~full_q[lnk_vc];
  assign rd_en = port_if.out_grant & full_q[xb_vc];

  // X is resolved before Y; the hop consumed by this router is removed here.
  always_comb begin
    routed_pkt = port_if.di;
    routed_dir = DirPe;
    if (hx != 8'd0) begin
      routed_pkt[55:48] = hx - 8'd1;
      routed_dir        = port_if.di[62] ? DirW : DirE;
    end else if (hy != 8'd0) begin
      routed_pkt[47:40] = hy - 8'd1;
      routed_dir        = port_if.di[61] ? DirS : DirN;
    end
  end

  always_comb begin
    pkt_buf_d   = pkt_buf_q;
    dir_d       = dir_q;
    full_d      = full_q;
    pkt_count_d = pkt_count_q;
    if (wr_en) begin
      pkt_buf_d[lnk_vc] = routed_pkt;
      dir_d[lnk_vc]     = routed_dir;
      full_d[lnk_vc]    = 1'b1;
      pkt_count_d       = pkt_count_q + 16'd1;
    end
    // Write and grant always target opposite VCs, so both may apply in one edge.
    if (rd_en) begin
      pkt_buf_d[xb_vc] = '0;
      full_d[xb_vc]    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pkt_buf_q   <= '{default: '0};
      dir_q       <= '{default: '0};
      full_q      <= '0;
      pkt_count_q <= '0;
    end else begin
      pkt_buf_q   <= pkt_buf_d;
      dir_q       <= dir_d;
      full_q      <= full_d;
      pkt_count_q <= pkt_count_d;
    end
  end

  always_comb begin
    port_if.ri        = ~full_q[lnk_vc];
    port_if.out_valid = full_q[xb_vc];
    port_if.out_data  = '0;
    port_if.out_dir   = '0;
    if (full_q[xb_vc]) begin
      port_if.out_data = pkt_buf_q[xb_vc];
      port_if.out_dir  = dir_q[xb_vc];
    end
  end

  assign pkt_count_o = pkt_count_q;

endmodule

// File: tb/tb_router_input_port.sv
// Directed bench for router_input_port with a reference model of the VC flags and
// an in-order scoreboard of routed packets.
module tb_router_input_port;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        polarity = 1'b0;
  logic [15:0] pkt_count;

  router_input_port_if #(.PACKET_WIDTH(64)) bus ();

  router_input_port #(.PACKET_WIDTH(64)) dut (
    .clk         (clk),
    .reset       (reset),
    .polarity_i  (polarity),
    .port_if     (bus.slave),
    .pkt_count_o (pkt_count)
  );

  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // Reference model state.
  logic [1:0]  full_m = 2'b00;
  logic [15:0] cnt_m  = 16'd0;
  logic [66:0] sb[$];

  logic        cur_pol, cur_si, cur_g, cur_rst;
  logic [63:0] cur_di;

  function automatic logic [66:0] route_m(input logic [63:0] d);
    logic [63:0] o;
    o = d;
    if (d[55:48] != 8'd0) begin
      o[55:48] = d[55:48] - 8'd1;
      return {(d[62] ? 3'd1 : 3'd0), o};
    end
    if (d[47:40] != 8'd0) begin
      o[47:40] = d[47:40] - 8'd1;
      return {(d[61] ? 3'd3 : 3'd2), o};
    end
    return {3'd4, o};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs, then compare outputs against the model mid-cycle.
  task automatic drive(input logic pol, input logic s, input logic [63:0] d, input logic g,
                       input logic r, input bit do_chk);
    logic [66:0] head;
    cur_pol = pol; cur_si = s; cur_di = d; cur_g = g; cur_rst = r;
    polarity = pol; bus.si = s; bus.di = d; bus.out_grant = g; reset = r;
    #2;
    if (do_chk) begin
      chk("ri", {63'd0, bus.ri}, {63'd0, ~full_m[pol]});
      chk("out_valid", {63'd0, bus.out_valid}, {63'd0, full_m[~pol]});
      if (full_m[~pol]) begin
        chk("sb_nonempty", {63'd0, sb.size() > 0}, 64'd1);
        head = (sb.size() > 0) ? sb[0] : 67'd0;
        chk("out_data", bus.out_data, head[63:0]);
        chk("out_dir", {61'd0, bus.out_dir}, {61'd0, head[66:64]});
      end else begin
        chk("idle_data", bus.out_data, 64'd0);
        chk("idle_dir", {61'd0, bus.out_dir}, 64'd0);
      end
      chk("pkt_count", {48'd0, pkt_count}, {48'd0, cnt_m});
    end
  endtask

  task automatic tick();
    logic acc, gnt;
    if (!cur_rst) begin
      full_m = 2'b00;
      cnt_m  = 16'd0;
      sb.delete();
    end else begin
      acc = cur_si & ~full_m[cur_pol];
      gnt = cur_g & full_m[~cur_pol];
      if (gnt) begin
        full_m[~cur_pol] = 1'b0;
        void'(sb.pop_front());
      end
      if (acc) begin
        full_m[cur_pol] = 1'b1;
        sb.push_back(route_m(cur_di));
        cnt_m = cnt_m + 16'd1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic pol, input logic s, input logic [63:0] d, input logic g);
    drive(pol, s, d, g, 1'b1, 1'b1);
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic p;
    bus.si = 1'b0; bus.di = '0; bus.out_grant = 1'b0;
    #1;

    // Reset for two cycles with si asserted.
    drive(1'b0, 1'b1, 64'h1111_0000_0000_0001, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b0, 1'b1, 64'h1111_0000_0000_0001, 1'b0, 1'b0, 1'b1);
    chk("rst_ri", {63'd0, bus.ri}, 64'd1);
    chk("rst_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("rst_data", bus.out_data, 64'd0);
    chk("rst_count", {48'd0, pkt_count}, 64'd0);
    tick();

    // East route.
    step(1'b0, 1'b1, 64'h0003_0000_0000_00AA, 1'b0);
    drive(1'b1, 1'b0, 64'd0, 1'b1, 1'b1, 1'b1);
    chk("east_valid", {63'd0, bus.out_valid}, 64'd1);
    chk("east_dir", {61'd0, bus.out_dir}, 64'd0);
    chk("east_data", bus.out_data, 64'h0002_0000_0000_00AA);
    chk("east_ri", {63'd0, bus.ri}, 64'd1);
    tick();
    step(1'b0, 1'b0, 64'd0, 1'b0);
    drive(1'b1, 1'b0, 64'd0, 1'b0, 1'b1, 1'b1);
    chk("east_cleared", {63'd0, bus.out_valid}, 64'd0);
    tick();

    // South and PE routes on VC0, west and north routes on VC1.
    step(1'b0, 1'b1, 64'h2000_0200_0000_0001, 1'b0);
    drive(1'b1, 1'b0, 64'd0, 1'b1, 1'b1, 1'b1);
    chk("south_dir", {61'd0, bus.out_dir}, 64'd3);
    chk("south_data", bus.out_data, 64'h2000_0100_0000_0001);
    tick();
    step(1'b0, 1'b1, 64'h0000_0000_0000_0005, 1'b0);
    drive(1'b1, 1'b1, 64'h4001_0000_0000_0007, 1'b1, 1'b1, 1'b1);
    chk("pe_dir", {61'd0, bus.out_dir}, 64'd4);
    chk("pe_data", bus.out_data, 64'h0000_0000_0000_0005);
    tick();
    drive(1'b0, 1'b0, 64'd0, 1'b1, 1'b1, 1'b1);
    chk("west_dir", {61'd0, bus.out_dir}, 64'd1);
    chk("west_data", bus.out_data, 64'h4000_0000_0000_0007);
    tick();
    step(1'b1, 1'b1, 64'h0000_0500_0000_0009, 1'b0);
    drive(1'b0, 1'b0, 64'd0, 1'b1, 1'b1, 1'b1);
    chk("north_dir", {61'd0, bus.out_dir}, 64'd2);
    chk("north_data", bus.out_data, 64'h0000_0400_0000_0009);
    tick();

    // Backpressure with polarity held.
    drive(1'b0, 1'b0, 64'd0, 1'b0, 1'b0, 1'b0);
    tick();
    step(1'b0, 1'b1, 64'h0001_0000_0000_00A0, 1'b0);
    drive(1'b0, 1'b1, 64'h0000_0000_0000_00B0, 1'b0, 1'b1, 1'b1);
    chk("bp_ri_low", {63'd0, bus.ri}, 64'd0);
    chk("bp_not_presented", {63'd0, bus.out_valid}, 64'd0);
    tick();
    drive(1'b1, 1'b0, 64'd0, 1'b1, 1'b1, 1'b1);
    chk("bp_count1", {48'd0, pkt_count}, 64'd1);
    chk("bp_a_data", bus.out_data, 64'h0000_0000_0000_00A0);
    tick();
    drive(1'b0, 1'b1, 64'h0000_0000_0000_00B0, 1'b0, 1'b1, 1'b1);
    chk("bp_ri_high", {63'd0, bus.ri}, 64'd1);
    tick();
    drive(1'b1, 1'b0, 64'd0, 1'b1, 1'b1, 1'b1);
    chk("bp_count2", {48'd0, pkt_count}, 64'd2);
    chk("bp_b_data", bus.out_data, 64'h0000_0000_0000_00B0);
    tick();

    // Write VC0 and grant VC1 on the same edge.
    step(1'b1, 1'b1, 64'h0000_0000_0000_0C01, 1'b0);
    step(1'b0, 1'b1, 64'h0000_0000_0000_0C02, 1'b1);
    drive(1'b1, 1'b0, 64'd0, 1'b0, 1'b1, 1'b1);
    chk("sim_vc1_freed", {63'd0, bus.ri}, 64'd1);
    chk("sim_vc0_written", bus.out_data, 64'h0000_0000_0000_0C02);
    tick();

    // Reset mid-operation overrides a pending grant and write.
    drive(1'b1, 1'b1, 64'h0000_0000_0000_0D01, 1'b1, 1'b0, 1'b1);
    tick();
    drive(1'b1, 1'b0, 64'd0, 1'b0, 1'b1, 1'b1);
    chk("midrst_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("midrst_count", {48'd0, pkt_count}, 64'd0);
    tick();

    // Streaming: 20 packets, toggling polarity, grant every cycle.
    p = 1'b0;
    for (int i = 0; i < 20; i++) begin
      drive(p, 1'b1, {8'h00, 8'(i % 3), 8'(i % 2), 24'd0, 16'(16'h5000 + i)}, 1'b1, 1'b1, 1'b1);
      chk("stream_ri", {63'd0, bus.ri}, 64'd1);
      tick();
      p = ~p;
    end
    drive(p, 1'b0, 64'd0, 1'b1, 1'b1, 1'b1);
    chk("stream_last", bus.out_data[15:0], 64'h5013);
    chk("stream_count", {48'd0, pkt_count}, 64'd20);
    tick();
    p = ~p;

    // Counter wrap.
    while (cnt_m != 16'hFFFF) begin
      step(p, 1'b1, {48'd0, cnt_m}, 1'b1);
      p = ~p;
    end
    drive(p, 1'b0, 64'd0, 1'b1, 1'b1, 1'b1);
    chk("wrap_ffff", {48'd0, pkt_count}, 64'h0000_0000_0000_FFFF);
    tick();
    p = ~p;
    step(p, 1'b1, 64'h0000_0000_0000_0E01, 1'b1);
    p = ~p;
    drive(p, 1'b0, 64'd0, 1'b1, 1'b1, 1'b1);
    chk("wrap_zero", {48'd0, pkt_count}, 64'd0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/router_input_port.md
# router_input_port

Router-side input channel stage that directly consumes the NIC's network output channel (`net_so`/`net_ro`/`net_do`), or a neighbouring router's output channel.

- Holds one packet per virtual channel in two buffers, even (VC0) and odd (VC1).
- Decodes the XY route from the header and decrements the consumed hop count.
- Presents the packet to the crossbar/arbiter with a valid/grant handshake.
- Polarity decides which VC faces the link and which faces the crossbar in a given cycle.

## Interface

- `PACKET_WIDTH`, 64, packet width; header fields below assume 64.
- `clk` in 1: the single clock; all state changes on the rising edge.
- `reset` in 1: synchronous, active-low; `reset==0` at a rising edge resets all state.
- `polarity` in 1: router phase. Link side uses VC[`polarity`]; crossbar side uses VC[~`polarity`].
- `si` in 1: send strobe from upstream (NIC `net_so`).
- `ri` out 1: ready to upstream (NIC `net_ro`); combinational, equals `~full[polarity]`.
- `di` in `PACKET_WIDTH`: packet from upstream (NIC `net_do`).
- `out_valid` out 1: crossbar-side VC holds a packet; combinational, equals `full[~polarity]`.
- `out_dir` out 3: route of the crossbar-side packet. 0=E(+x), 1=W(−x), 2=N(+y), 3=S(−y), 4=PE (local).
- `out_data` out `PACKET_WIDTH`: crossbar-side packet with hop counts already updated.
- `out_grant` in 1: arbiter accepts the crossbar-side packet this cycle.
- `pkt_count` out 16: number of packets accepted since reset; wraps.

## Operation

Header fields:
- [63] vc: carried through unchanged and not checked.
- [62] xdir: 0=+x, 1=−x.
- [61] ydir: 0=+y, 1=−y.
- [55:48] hx: remaining x hops.
- [47:40] hy: remaining y hops.
- All other bits are carried through unchanged.

Per-VC state: `buf[v]` (`PACKET_WIDTH`), `dir[v]` (3 bits), `full[v]`.

Link-side write:
- Condition: `si && ri` at an edge.
- `buf[polarity]`, `dir[polarity]` and `full[polarity]` are written; `full[polarity]` is set to 1.
- `pkt_count` increments by 1 and wraps 0xFFFF→0.
- If `si` is high while `ri` is low, nothing is written. The upstream block holds and retries; there is no drop.

XY route, computed from the incoming `di` at write time:
- `hx!=0`: dir = xdir ? W : E; stored hx = hx−1.
- Else `hy!=0`: dir = ydir ? S : N; stored hy = hy−1.
- Else: dir = PE; stored packet equals `di`.
- Decrement is 8-bit. It never underflows, because a field is only decremented when it is nonzero.

Crossbar-side read:
- `out_data` = `buf[~polarity]` and `out_dir` = `dir[~polarity]` whenever `out_valid` is 1.
- When `out_valid` is 0, `out_data` and `out_dir` are 0.
- `out_grant && out_valid` clears `full[~polarity]` and `buf[~polarity]` (to 0) at the edge.
- `out_grant` while `out_valid==0` is ignored.

Other behaviour:
- A write to VC[p] and a grant on VC[~p] in the same cycle are independent; both take effect.
- A write and a grant never target the same VC in the same cycle.
- No state machine beyond the per-VC full flags. The link side and crossbar side are fully decoupled by polarity.

## Timing

- Reset values:
  - `full` = 00, `buf` = 0, `dir` = 0, `pkt_count` = 0.
  - Hence `ri`=1 (both VCs empty), `out_valid`=0, `out_data`=0, `out_dir`=0.
- Reset mid-operation: any held packet is discarded, with no output activity. Reset has priority over a simultaneous write or grant.
- Write latency: a packet accepted at edge T with `polarity`=p is visible on `out_*` in the first cycle after T in which `polarity`=~p.
  - With `polarity` toggling every cycle, that is the cycle immediately after T.
- `ri` for VC p drops in the cycle after the accepting edge and stays low until VC p is granted during a ~p phase.
- Back-to-back accepts: with toggling polarity and a grant every cycle, one packet per cycle is sustained by alternating VCs.
- If `polarity` is held constant, at most one packet is accepted before `ri` goes low. The held packet is not presented until polarity flips.
- All outputs except `ri`, `out_valid`, `out_data` and `out_dir` are registered. Those four are combinational selects of registered state by `polarity`.

## Test plan

- **Reset:** hold `reset`=0 for 2 cycles with `si`=1 → `ri`=1, `out_valid`=0, `out_data`=0, `pkt_count`=0, no write.
- **East route:**
  - Stimulus: `polarity`=0, `si`=1, `di`=0x0003_0000_0000_00AA (hx=3, hy=0, xdir=0).
  - Next cycle (`polarity`=1): `out_valid`=1, `out_dir`=0, `out_data`=0x0002_0000_0000_00AA, `ri`=1.
  - Grant that cycle → next polarity=1 phase shows `out_valid`=0.
- **Y and PE routes:**
  - `di`=0x2000_0200_0000_0001 (hx=0, hy=2, ydir=1) → `out_dir`=3, hy=1 in `out_data`.
  - `di`=0x0000_0000_0000_0005 → `out_dir`=4, `out_data` equal to `di`.
- **Backpressure:**
  - Stimulus: `polarity` held 0; send packet A, then assert `si` with B.
  - Required: `ri`=0 after A, B is not accepted, `pkt_count`=1.
  - Toggle `polarity` and grant A; on the next polarity=0 phase `ri`=1 and B is accepted, `pkt_count`=2.
- **Streaming:**
  - Stimulus: `polarity` toggles every cycle, `si`=1 with 20 distinct packets, `out_grant`=1 every cycle.
  - Required: 20 packets emerge in order, each one cycle after acceptance; `pkt_count`=20; `ri` never low.
- **Simultaneous write/grant and wrap:**
  - A grant on VC1 and a write on VC0 in the same edge both complete.
  - Preload `pkt_count` to 0xFFFF via 65535 accepts; one more accept → 0x0000.
